cpu6_dmem_resp: RTL and testbench

Data-memory responder for the cpu6 core's data port (memwrite/dataaddr/writedata/readdata). It services the core's single-cycle accesses with a zero-wait combinational read and a clock-edge write, backed by a word RAM. It also exposes a small MMIO window: a free-running mtime counter, mtimecmp with a timer interrupt, and a tohost halt register. It also reports misaligned and unmapped accesses as registered fault pulses. It sits beside cpu6_core at the SoC top level.

---
 rtl/cpu6_dmem_resp_pkg.sv | 34 +++
 rtl/cpu6_dmem_timer.sv | 28 ++
 rtl/cpu6_dmem_resp.sv | 84 ++++++++
 tb/tb_cpu6_dmem_resp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_dmem_resp_pkg.sv
// Shared address map and decode helper for the cpu6 data-memory responder.
package cpu6_dmem_resp_pkg;

  localparam int          CPU6_XLEN               = 64;
  localparam logic [31:0] CPU6_DMEM_RAM_BASE      = 32'h0000_0000;
  localparam logic [31:0] CPU6_DMEM_MMIO_BASE     = 32'h1000_0000;
  localparam logic [31:0] CPU6_DMEM_MTIME_ADDR    = CPU6_DMEM_MMIO_BASE + 32'h0;
  localparam logic [31:0] CPU6_DMEM_MTIMECMP_ADDR = CPU6_DMEM_MMIO_BASE + 32'h8;
  localparam logic [31:0] CPU6_DMEM_TOHOST_ADDR   = CPU6_DMEM_MMIO_BASE + 32'h10;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_MTIME,
    SEL_MTIMECMP,
    SEL_TOHOST
  } dsel_e;

  // SEL_NONE covers both misaligned and unmapped accesses.
  function automatic dsel_e decode(input logic [31:0] addr_lo,
                                   input logic        hi_zero,
                                   input logic [31:0] ram_bytes);
    dsel_e sel;
    sel = SEL_NONE;
    if (hi_zero && (addr_lo[2:0] == 3'b000)) begin
      if ((addr_lo - CPU6_DMEM_RAM_BASE) < ram_bytes) sel = SEL_RAM;
      else if (addr_lo == CPU6_DMEM_MTIME_ADDR)        sel = SEL_MTIME;
      else if (addr_lo == CPU6_DMEM_MTIMECMP_ADDR)     sel = SEL_MTIMECMP;
      else if (addr_lo == CPU6_DMEM_TOHOST_ADDR)       sel = SEL_TOHOST;
    end
    return sel;
  endfunction

endpackage

// File: rtl/cpu6_dmem_timer.sv
// mtime/mtimecmp pair with write-over-increment priority and registered timer irq.
module cpu6_dmem_timer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mtime_we,
  input  logic            mtimecmp_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] mtime,
  output logic [XLEN-1:0] mtimecmp,
  output logic            timer_irq
);

  // irq samples the register outputs, so it trails the compare by one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_we ? wdata : mtime + XLEN'(1);
      if (mtimecmp_we) mtimecmp <= wdata;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/cpu6_dmem_resp.sv
// cpu6 data-port responder: zero-wait word RAM, mtime/mtimecmp/tohost MMIO, fault reporting.
module cpu6_dmem_resp
  import cpu6_dmem_resp_pkg::*;
#(
  parameter int XLEN        = CPU6_XLEN,
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = "dmem.hex"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwrite,
  input  logic [XLEN-1:0] dataaddr,
  input  logic [XLEN-1:0] writedata,
  output logic [XLEN-1:0] readdata,
  output logic            timer_irq,
  output logic            halt,
  output logic [XLEN-1:0] tohost_val,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 8);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] mtime;
  logic [XLEN-1:0] mtimecmp;
  logic [AW-1:0]   widx;
  logic            hi_zero;
  dsel_e           sel;

  assign hi_zero = (dataaddr[XLEN-1:32] == '0);
  assign sel     = decode(dataaddr[31:0], hi_zero, RAM_BYTES);
  assign widx    = dataaddr[AW+2:3];

  // RAM is deliberately outside reset so contents survive a core restart.
  always_ff @(posedge clk) begin
    if (memwrite && (sel == SEL_RAM)) mem[widx] <= writedata;
  end

  always_comb begin
    readdata = '0;
    unique case (sel)
      SEL_RAM:      readdata = mem[widx];
      SEL_MTIME:    readdata = mtime;
      SEL_MTIMECMP: readdata = mtimecmp;
      SEL_TOHOST:   readdata = tohost_val;
      default:      readdata = '0;
    endcase
  end

  cpu6_dmem_timer #(.XLEN(XLEN)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .mtime_we    (memwrite && (sel == SEL_MTIME)),
    .mtimecmp_we (memwrite && (sel == SEL_MTIMECMP)),
    .wdata       (writedata),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .timer_irq   (timer_irq)
  );

  // tohost latches only once; zero writes before halt are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt       <= 1'b0;
      tohost_val <= '0;
    end else if (!halt && memwrite && (sel == SEL_TOHOST) && (writedata != '0)) begin
      halt       <= 1'b1;
      tohost_val <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      fault <= (sel == SEL_NONE);
      if (sel == SEL_NONE) fault_addr <= dataaddr;
    end
  end

endmodule

// File: tb/tb_cpu6_dmem_resp.sv
// Scoreboard bench for cpu6_dmem_resp: stimulus queues expectations, a negedge monitor checks them.
module tb_cpu6_dmem_resp;

  localparam logic [63:0] A_MTIME    = 64'h1000_0000;
  localparam logic [63:0] A_MTIMECMP = 64'h1000_0008;
  localparam logic [63:0] A_TOHOST   = 64'h1000_0010;
  localparam logic [63:0] DEAD       = 64'hDEAD_BEEF_CAFE_F00D;

  localparam int S_RD = 0, S_FAULT = 1, S_FADDR = 2, S_IRQ = 3, S_HALT = 4, S_TOHOST = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [63:0] dataaddr;
  logic [63:0] writedata;
  logic [63:0] readdata;
  logic        timer_irq;
  logic        halt;
  logic [63:0] tohost_val;
  logic        fault;
  logic [63:0] fault_addr;

  cpu6_dmem_resp dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataaddr   (dataaddr),
    .writedata  (writedata),
    .readdata   (readdata),
    .timer_irq  (timer_irq),
    .halt       (halt),
    .tohost_val (tohost_val),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] probe(input int sig);
    case (sig)
      S_RD:     return readdata;
      S_FAULT:  return {63'b0, fault};
      S_FADDR:  return fault_addr;
      S_IRQ:    return {63'b0, timer_irq};
      S_HALT:   return {63'b0, halt};
      S_TOHOST: return tohost_val;
      default:  return 'x;
    endcase
  endfunction

  // Monitor: every entry due this cycle is compared; overdue entries are failures.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [63:0] act;
        act = probe(sb[i].sig);
        n_tests++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s overdue: due cycle %0d, seen cycle %0d", sb[i].nm, sb[i].cyc, cyc);
        end else if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cycle %0d: actual=%h required=%h", sb[i].nm, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_v(input int off, input int sig, input logic [63:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + off;
    e.sig = sig;
    e.val = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic we, input logic [63:0] a, input logic [63:0] d);
    @(posedge clk);
    #1;
    memwrite  = we;
    dataaddr  = a;
    writedata = d;
  endtask

  initial begin
    reset     = 1'b0;
    memwrite  = 1'b0;
    dataaddr  = '0;
    writedata = '0;

    // Reset state
    step(1'b0, 64'h0, 64'h0);
    expect_v(0, S_HALT,   64'h0, "rst_halt");
    expect_v(0, S_TOHOST, 64'h0, "rst_tohost");
    expect_v(0, S_FAULT,  64'h0, "rst_fault");
    expect_v(0, S_FADDR,  64'h0, "rst_faddr");
    expect_v(0, S_IRQ,    64'h0, "rst_irq");
    @(posedge clk); #1 reset = 1'b1;

    // Basic RAM write then read
    step(1'b1, 64'h18, DEAD);
    expect_v(1, S_FAULT, 64'h0, "wr18_nofault");
    step(1'b0, 64'h18, 64'h0);
    expect_v(0, S_RD,    DEAD,  "rd18");
    expect_v(1, S_FAULT, 64'h0, "rd18_nofault");

    // Read-during-write returns old data
    step(1'b1, 64'h20, 64'h2222);
    step(1'b1, 64'h20, 64'h1111);
    expect_v(0, S_RD, 64'h2222, "rdw_old");
    step(1'b0, 64'h20, 64'h0);
    expect_v(0, S_RD, 64'h1111, "rdw_new");

    // Top RAM word is mapped, one past it is not
    step(1'b1, 64'h1FF8, 64'h77);
    expect_v(1, S_FAULT, 64'h0, "ramtop_nofault");
    step(1'b0, 64'h1FF8, 64'h0);
    expect_v(0, S_RD, 64'h77, "rd_ramtop");
    step(1'b0, 64'h2000, 64'h0);
    expect_v(0, S_RD,    64'h0,    "rd_ramend");
    expect_v(1, S_FAULT, 64'h1,    "ramend_fault");
    expect_v(1, S_FADDR, 64'h2000, "ramend_faddr");

    // Misaligned write is suppressed and faults for one cycle
    step(1'b1, 64'h1C, 64'h9999);
    expect_v(0, S_RD,    64'h0,  "rd_misal");
    expect_v(1, S_FAULT, 64'h1,  "misal_fault");
    expect_v(1, S_FADDR, 64'h1C, "misal_faddr");
    step(1'b0, 64'h18, 64'h0);
    expect_v(0, S_RD,    DEAD,  "rd18_after_misal");
    expect_v(1, S_FAULT, 64'h0, "misal_pulse_end");

    // Unmapped read
    step(1'b0, 64'h2000_0000, 64'h0);
    expect_v(0, S_RD,    64'h0,         "rd_unmapped");
    expect_v(1, S_FAULT, 64'h1,         "unmap_fault");
    expect_v(1, S_FADDR, 64'h2000_0000, "unmap_faddr");

    // Back-to-back bad accesses, including nonzero upper bits
    step(1'b0, 64'h1000_0018, 64'h0);
    expect_v(1, S_FAULT, 64'h1,           "b2b_fault0");
    expect_v(1, S_FADDR, 64'h1000_0018,   "b2b_faddr0");
    step(1'b1, 64'h1_0000_0000, 64'h5555);
    expect_v(0, S_RD,    64'h0,           "rd_hibits");
    expect_v(1, S_FAULT, 64'h1,           "b2b_fault1");
    expect_v(1, S_FADDR, 64'h1_0000_0000, "b2b_faddr1");
    step(1'b0, 64'h0, 64'h0);
    expect_v(1, S_FAULT, 64'h0, "b2b_end");
    expect_v(0, S_RD,    64'hx, "dummy") ; sb.delete(sb.size() - 1);

    // Timer compare and irq latency
    step(1'b1, A_MTIME, 64'h0);
    step(1'b1, A_MTIMECMP, 64'd10);
    expect_v(10, S_IRQ, 64'h0, "irq_before");
    expect_v(11, S_IRQ, 64'h1, "irq_rise");
    step(1'b0, A_MTIMECMP, 64'h0);
    expect_v(0, S_RD, 64'd10, "rd_mtimecmp");
    step(1'b0, A_MTIME, 64'h0);
    expect_v(0, S_RD, 64'd2, "rd_mtime_count");
    repeat (9) step(1'b0, 64'h18, 64'h0);
    step(1'b1, A_MTIME, 64'h0);
    expect_v(1, S_IRQ, 64'h1, "irq_hold");
    expect_v(2, S_IRQ, 64'h0, "irq_drop");
    step(1'b0, A_MTIME, 64'h0);
    expect_v(0, S_RD, 64'h0, "rd_mtime_cleared");

    // mtime wrap and write-over-increment
    step(1'b1, A_MTIME, '1);
    expect_v(1, S_FAULT, 64'h0, "mtime_wr_nofault");
    step(1'b0, A_MTIME, 64'h0);
    expect_v(0, S_RD, '1, "rd_mtime_max");
    step(1'b0, A_MTIME, 64'h0);
    expect_v(0, S_RD, 64'h0, "rd_mtime_wrap");
    step(1'b1, A_MTIME, 64'h1234);
    step(1'b0, A_MTIME, 64'h0);
    expect_v(0, S_RD, 64'h1234, "mtime_load_exact");
    step(1'b0, A_MTIME, 64'h0);
    expect_v(0, S_RD, 64'h1235, "mtime_inc_after_load");

    // tohost: zero ignored, first nonzero latches, later writes ignored
    step(1'b1, A_TOHOST, 64'h0);
    expect_v(1, S_HALT,   64'h0, "tohost0_halt");
    expect_v(1, S_TOHOST, 64'h0, "tohost0_val");
    step(1'b1, A_TOHOST, 64'h1);
    expect_v(1, S_HALT,   64'h1, "tohost1_halt");
    expect_v(1, S_TOHOST, 64'h1, "tohost1_val");
    step(1'b1, A_TOHOST, 64'h5);
    expect_v(1, S_HALT,   64'h1, "tohost5_halt");
    expect_v(1, S_TOHOST, 64'h1, "tohost5_val");
    step(1'b0, A_TOHOST, 64'h0);
    expect_v(0, S_RD, 64'h1, "rd_tohost");

    // Asynchronous reset mid-run: registers clear, RAM keeps contents
    @(posedge clk);
    #1;
    reset    = 1'b0;
    memwrite = 1'b0;
    dataaddr = 64'h18;
    expect_v(0, S_HALT,   64'h0, "mid_rst_halt");
    expect_v(0, S_TOHOST, 64'h0, "mid_rst_tohost");
    expect_v(0, S_FAULT,  64'h0, "mid_rst_fault");
    expect_v(0, S_FADDR,  64'h0, "mid_rst_faddr");
    expect_v(0, S_IRQ,    64'h0, "mid_rst_irq");
    expect_v(0, S_RD,     DEAD,  "mid_rst_ram_kept");
    step(1'b0, A_MTIME, 64'h0);
    expect_v(0, S_RD, 64'h0, "mid_rst_mtime");
    @(posedge clk);
    #1;
    reset    = 1'b1;
    dataaddr = A_MTIMECMP;
    expect_v(0, S_RD, '1, "post_rst_mtimecmp");
    step(1'b0, 64'h18, 64'h0);
    expect_v(0, S_RD, DEAD, "post_rst_ram18");
    step(1'b0, A_TOHOST, 64'h0);
    expect_v(0, S_RD, 64'h0, "post_rst_tohost_rd");

    repeat (3) step(1'b0, 64'h0, 64'h0);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never checked: due cycle %0d", sb[0].nm, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
